// File: rtl/xdma_cfg_pkg.sv
// xdma_cfg_pkg
// Shared definitions for the XDMA configuration sequencer:
//   - LUT entry opcodes and write-merge modes
//   - bit positions of the fields inside a 69-bit LUT entry
//   - PCI Express capability ID used to validate capability headers
//   - response watchdog length (only used when XDMA_SEQ_TIMEOUT_EN is defined)
//   - sequencer state encoding
//   - helper that builds the write data from the last read and the LUT data
package xdma_cfg_pkg;

  typedef enum logic [2:0] {
    OP_CFG_WR = 3'b000,
    OP_CFG_RD = 3'b001,
    OP_BAR_WR = 3'b010,
    OP_BAR_RD = 3'b011,
    OP_END    = 3'b100
  } op_e;

  typedef enum logic [1:0] {
    MODE_SET = 2'b00,
    MODE_AND = 2'b01,
    MODE_OR  = 2'b10,
    MODE_BAD = 2'b11
  } mode_e;

  // LUT entry layout: {mode, op, addr, data}
  localparam int LUT_W   = 69;
  localparam int MODE_HI = 68;
  localparam int MODE_LO = 67;
  localparam int OP_HI   = 66;
  localparam int OP_LO   = 64;
  localparam int ADDR_HI = 63;
  localparam int ADDR_LO = 32;
  localparam int DATA_HI = 31;
  localparam int DATA_LO = 0;

  localparam logic [7:0] PCIE_CAP_ID = 8'h10;

  localparam int TIMEOUT_CYCLES = 1024;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_MERGE,
    ST_PAUSE,
    ST_DONE,
    ST_ERROR
  } state_e;

  // Read-modify-write data for a write entry. MODE_BAD never reaches here
  // because the sequencer traps it before issuing.
  function automatic logic [31:0] merge_wdata(input logic [1:0]  mode,
                                              input logic [31:0] last_rd,
                                              input logic [31:0] data);
    case (mode)
      MODE_AND: return last_rd & data;
      MODE_OR:  return last_rd | data;
      default:  return data;
    endcase
  endfunction

endpackage

// File: rtl/xdma_seq_capture.sv
// xdma_seq_capture
// Holds the values that later LUT entries depend on, captured from read
// results at fixed LUT indices while the sequencer is in its MERGE cycle.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   en              - high during the MERGE cycle of a read entry
//   index           - LUT index of the read being merged
//   rdata           - data returned by that read
//   hdr_err         - combinational: a capability header read did not return
//                     the PCIe capability ID
//   cap_ptr_dev, cap_ptr, pxcap_dev, pxcap - capability pointers
//   mpss            - negotiated max payload size (minimum of both sides)
//   pxdc_data       - last captured device-control word
module xdma_seq_capture
  import xdma_cfg_pkg::*;
#(
  parameter logic [31:0] IDX_CAP_DEV   = 32'd13,
  parameter logic [31:0] IDX_CAP       = 32'd15,
  parameter logic [31:0] IDX_PXCAP_DEV = 32'd14,
  parameter logic [31:0] IDX_PXCAP     = 32'd16,
  parameter logic [31:0] IDX_DCAP_DEV  = 32'd17,
  parameter logic [31:0] IDX_DCAP      = 32'd18,
  parameter logic [31:0] IDX_PXDC_DEV  = 32'd19,
  parameter logic [31:0] IDX_PXDC      = 32'd21
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] index,
  input  logic [31:0] rdata,
  output logic        hdr_err,
  output logic [7:0]  cap_ptr,
  output logic [7:0]  cap_ptr_dev,
  output logic [7:0]  pxcap,
  output logic [7:0]  pxcap_dev,
  output logic [2:0]  mpss,
  output logic [31:0] pxdc_data
);

  logic hdr_idx;

  // A capability header read must return the PCIe capability ID; anything
  // else means the pointer chain is broken and the walk cannot continue.
  assign hdr_idx = (index == IDX_PXCAP_DEV) || (index == IDX_PXCAP);
  assign hdr_err = en && hdr_idx && (rdata[7:0] != PCIE_CAP_ID);

  // Index-matched capture registers. The PCIe capability location is only
  // committed once its header has been validated. MPSS takes the device
  // value first and then the minimum with the bridge side.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_ptr     <= '0;
      cap_ptr_dev <= '0;
      pxcap       <= '0;
      pxcap_dev   <= '0;
      mpss        <= '0;
      pxdc_data   <= '0;
    end else if (en) begin
      if (index == IDX_CAP_DEV)
        cap_ptr_dev <= rdata[7:0];
      if (index == IDX_CAP)
        cap_ptr <= rdata[7:0];
      if (index == IDX_PXCAP_DEV && !hdr_err)
        pxcap_dev <= cap_ptr_dev;
      if (index == IDX_PXCAP && !hdr_err)
        pxcap <= cap_ptr;
      if (index == IDX_DCAP_DEV)
        mpss <= rdata[2:0];
      if (index == IDX_DCAP)
        mpss <= (rdata[2:0] < mpss) ? rdata[2:0] : mpss;
      if (index == IDX_PXDC_DEV || index == IDX_PXDC)
        pxdc_data <= rdata;
    end
  end

endmodule

// File: rtl/xdma_config_seq.sv
// xdma_config_seq
// Walks the XDMA configuration LUT and executes each entry as a register
// access on the bridge (cfg space) or the NVMe controller (BAR space).
// Stops at intermediate END entries until go, and finishes at the last one.
// Optional feature: define XDMA_SEQ_TIMEOUT_EN to add a response watchdog
// that aborts an access after TIMEOUT_CYCLES cycles without reg_ack.
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   start, go                   - begin the walk / resume after a phase END
//   lut_index, lut_data         - LUT address out, entry {mode,op,addr,data} in
//   reg_req/we/bar/addr/wdata   - register access request, held until ack
//   reg_ack, reg_err, reg_rdata - access completion, error and read data
//   busy, phase_done, done, error - status
//   cap_ptr*, pxcap*, mpss, pxdc_data - captured values fed back to the LUT
module xdma_config_seq
  import xdma_cfg_pkg::*;
#(
  parameter int          LUT_DEPTH     = 42,
  parameter logic [31:0] IDX_CAP_DEV   = 32'd13,
  parameter logic [31:0] IDX_CAP       = 32'd15,
  parameter logic [31:0] IDX_PXCAP_DEV = 32'd14,
  parameter logic [31:0] IDX_PXCAP     = 32'd16,
  parameter logic [31:0] IDX_DCAP_DEV  = 32'd17,
  parameter logic [31:0] IDX_DCAP      = 32'd18,
  parameter logic [31:0] IDX_PXDC_DEV  = 32'd19,
  parameter logic [31:0] IDX_PXDC      = 32'd21
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              go,
  output logic [31:0]       lut_index,
  input  logic [LUT_W-1:0]  lut_data,
  output logic              reg_req,
  output logic              reg_we,
  output logic              reg_bar,
  output logic [31:0]       reg_addr,
  output logic [31:0]       reg_wdata,
  input  logic              reg_ack,
  input  logic              reg_err,
  input  logic [31:0]       reg_rdata,
  output logic              busy,
  output logic              phase_done,
  output logic              done,
  output logic              error,
  output logic [7:0]        cap_ptr,
  output logic [7:0]        cap_ptr_dev,
  output logic [7:0]        pxcap,
  output logic [7:0]        pxcap_dev,
  output logic [2:0]        mpss,
  output logic [31:0]       pxdc_data
);

  localparam logic [31:0] LAST_INDEX = 32'(LUT_DEPTH - 1);

  state_e      state;
  logic [31:0] last_rd;
  logic [1:0]  lut_mode;
  logic [2:0]  lut_op;
  logic [31:0] lut_addr;
  logic [31:0] lut_dval;
  logic        op_is_read;
  logic        hdr_err;

`ifdef XDMA_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] timer;
`else
  // No watchdog state in this build.
`endif

  // Split the current LUT entry into its fields.
  assign lut_mode   = lut_data[MODE_HI:MODE_LO];
  assign lut_op     = lut_data[OP_HI:OP_LO];
  assign lut_addr   = lut_data[ADDR_HI:ADDR_LO];
  assign lut_dval   = lut_data[DATA_HI:DATA_LO];
  assign op_is_read = lut_op[0];

  // Capture registers are written at the end of the MERGE cycle, using the
  // read data that was latched at the ack.
  xdma_seq_capture #(
    .IDX_CAP_DEV   (IDX_CAP_DEV),
    .IDX_CAP       (IDX_CAP),
    .IDX_PXCAP_DEV (IDX_PXCAP_DEV),
    .IDX_PXCAP     (IDX_PXCAP),
    .IDX_DCAP_DEV  (IDX_DCAP_DEV),
    .IDX_DCAP      (IDX_DCAP),
    .IDX_PXDC_DEV  (IDX_PXDC_DEV),
    .IDX_PXDC      (IDX_PXDC)
  ) u_capture (
    .clk         (clk),
    .rst         (rst),
    .en          (state == ST_MERGE),
    .index       (lut_index),
    .rdata       (last_rd),
    .hdr_err     (hdr_err),
    .cap_ptr     (cap_ptr),
    .cap_ptr_dev (cap_ptr_dev),
    .pxcap       (pxcap),
    .pxcap_dev   (pxcap_dev),
    .mpss        (mpss),
    .pxdc_data   (pxdc_data)
  );

  // Sequencer FSM with registered outputs. Access fields are loaded in FETCH
  // and stay untouched through ISSUE, so they are stable while reg_req is up.
  // ERROR is sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      lut_index  <= '0;
      reg_req    <= 1'b0;
      reg_we     <= 1'b0;
      reg_bar    <= 1'b0;
      reg_addr   <= '0;
      reg_wdata  <= '0;
      busy       <= 1'b0;
      phase_done <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      last_rd    <= '0;
`ifdef XDMA_SEQ_TIMEOUT_EN
      timer      <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            lut_index <= '0;
            busy      <= 1'b1;
            state     <= ST_FETCH;
          end
        end

        ST_FETCH: begin
          if (lut_op == OP_END) begin
            busy <= 1'b0;
            if (lut_index == LAST_INDEX) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              phase_done <= 1'b1;
              state      <= ST_PAUSE;
            end
          end else if (lut_op > OP_END ||
                       (!op_is_read && lut_mode == MODE_BAD)) begin
            busy  <= 1'b0;
            error <= 1'b1;
            state <= ST_ERROR;
          end else begin
            reg_req   <= 1'b1;
            reg_we    <= ~op_is_read;
            reg_bar   <= lut_op[1];
            reg_addr  <= lut_addr;
            reg_wdata <= op_is_read ? '0 : merge_wdata(lut_mode, last_rd, lut_dval);
`ifdef XDMA_SEQ_TIMEOUT_EN
            timer     <= '0;
`endif
            state     <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          if (reg_err) begin
            reg_req <= 1'b0;
            busy    <= 1'b0;
            error   <= 1'b1;
            state   <= ST_ERROR;
          end else if (reg_ack) begin
            reg_req <= 1'b0;
            if (!reg_we) begin
              last_rd <= reg_rdata;
              state   <= ST_MERGE;
            end else begin
              lut_index <= lut_index + 32'd1;
              state     <= ST_FETCH;
            end
          end
`ifdef XDMA_SEQ_TIMEOUT_EN
          else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
            reg_req <= 1'b0;
            busy    <= 1'b0;
            error   <= 1'b1;
            state   <= ST_ERROR;
          end else begin
            timer <= timer + 1'b1;
          end
`else
          // Without the watchdog the request is held until the target answers.
`endif
        end

        ST_MERGE: begin
          if (hdr_err) begin
            busy  <= 1'b0;
            error <= 1'b1;
            state <= ST_ERROR;
          end else begin
            lut_index <= lut_index + 32'd1;
            state     <= ST_FETCH;
          end
        end

        ST_PAUSE: begin
          if (go) begin
            phase_done <= 1'b0;
            busy       <= 1'b1;
            lut_index  <= lut_index + 32'd1;
            state      <= ST_FETCH;
          end
        end

        ST_DONE: begin
          if (start) begin
            done      <= 1'b0;
            busy      <= 1'b1;
            lut_index <= '0;
            state     <= ST_FETCH;
          end
        end

        ST_ERROR: begin
          error <= 1'b1;
        end

        default: state <= ST_ERROR;
      endcase
    end
  end

endmodule
